acore_pm_sweep_ctrl: RTL

Sequencer for the per-slice phase monitors of the time-interleaved ADC.
- Steps through the enabled ADC slices one at a time, asserting en_pm only for the current slice.
- Waits a programmable settle time, then a measure time, then samples that slice's 20-bit pm_out and emits it on a result write strobe.
- Sits in the digital core between the JTAG config registers and the analog-core en_pm/pm_out signals. It replaces static JTAG control of en_pm during sweeps.

---
 rtl/acore_pm_sweep_ctrl_if.sv | 45 ++++
 rtl/acore_pm_sweep_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/acore_pm_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer, its JTAG config source and the analog-core pm pins.
// ACORE_PM_SWEEP_MAX_EN adds the max_data/max_idx result signals.
interface acore_pm_sweep_ctrl_if #(
  parameter int Nti   = 16,
  parameter int PM_W  = 20,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(Nti);

  logic                  start;
  logic                  abort;
  logic [Nti-1:0]        slice_mask;
  logic [CNT_W-1:0]      settle_cycles;
  logic [CNT_W-1:0]      meas_cycles;
  logic [Nti*PM_W-1:0]   pm_out_flat;
  logic [Nti-1:0]        en_pm;
  logic                  res_wr;
  logic [IDX_W-1:0]      res_idx;
  logic [PM_W-1:0]       res_data;
  logic                  busy;
  logic                  done;

`ifdef ACORE_PM_SWEEP_MAX_EN
  logic [PM_W-1:0]       max_data;
  logic [IDX_W-1:0]      max_idx;

  modport master (
    output start, abort, slice_mask, settle_cycles, meas_cycles, pm_out_flat,
    input  en_pm, res_wr, res_idx, res_data, busy, done, max_data, max_idx
  );
  modport slave (
    input  start, abort, slice_mask, settle_cycles, meas_cycles, pm_out_flat,
    output en_pm, res_wr, res_idx, res_data, busy, done, max_data, max_idx
  );
`else
  modport master (
    output start, abort, slice_mask, settle_cycles, meas_cycles, pm_out_flat,
    input  en_pm, res_wr, res_idx, res_data, busy, done
  );
  modport slave (
    input  start, abort, slice_mask, settle_cycles, meas_cycles, pm_out_flat,
    output en_pm, res_wr, res_idx, res_data, busy, done
  );
`endif
endinterface

// File: rtl/acore_pm_sweep_ctrl.sv
// Phase-monitor sweep sequencer: enables one ADC slice at a time, waits settle+measure, captures pm_out.
// Optional ACORE_PM_SWEEP_MAX_EN tracks the largest captured word and its slice index.
module acore_pm_sweep_ctrl #(
  parameter int Nti   = 16,
  parameter int PM_W  = 20,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  acore_pm_sweep_ctrl_if.slave  sw
);
  localparam int IDX_W = $clog2(Nti);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Nti - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_SETTLE, S_MEAS, S_CAPTURE, S_FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [Nti-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [Nti-1:0]   en_pm_q, en_pm_d;
  logic             res_wr_q, res_wr_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;
  logic [PM_W-1:0]  res_data_q, res_data_d;
  logic [PM_W-1:0]  pm_sel;

  always_comb begin
    pm_sel = '0;
    for (int unsigned i = 0; i < Nti; i++) begin
      if (idx_q == IDX_W'(i)) pm_sel = sw.pm_out_flat[i*PM_W +: PM_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    settle_d   = settle_q;
    meas_d     = meas_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    en_pm_d    = en_pm_q;
    res_wr_d   = 1'b0;
    res_idx_d  = res_idx_q;
    res_data_d = res_data_q;
    if (sw.abort) begin
      state_d = S_IDLE;
      en_pm_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sw.start) begin
            mask_d   = sw.slice_mask;
            settle_d = sw.settle_cycles;
            meas_d   = sw.meas_cycles;
            idx_d    = '0;
            state_d  = (sw.slice_mask == '0) ? S_FINISH : S_SEEK;
          end
        end
        S_SEEK: begin
          if (mask_q[idx_q]) begin
            en_pm_d        = '0;
            en_pm_d[idx_q] = 1'b1;
            cnt_d          = settle_q;
            state_d        = S_SETTLE;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            cnt_d   = meas_q;
            state_d = S_MEAS;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_MEAS: begin
          // Sample and drop en_pm on the edge leaving MEAS so res_wr and en_pm=0 coincide with CAPTURE.
          if (cnt_q == '0) begin
            en_pm_d    = '0;
            res_wr_d   = 1'b1;
            res_idx_d  = idx_q;
            res_data_d = pm_sel;
            state_d    = S_CAPTURE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEEK;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      settle_q   <= '0;
      meas_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      en_pm_q    <= '0;
      res_wr_q   <= 1'b0;
      res_idx_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      settle_q   <= settle_d;
      meas_q     <= meas_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      en_pm_q    <= en_pm_d;
      res_wr_q   <= res_wr_d;
      res_idx_q  <= res_idx_d;
      res_data_q <= res_data_d;
    end
  end

  assign sw.en_pm    = en_pm_q;
  assign sw.res_wr   = res_wr_q;
  assign sw.res_idx  = res_idx_q;
  assign sw.res_data = res_data_q;
  assign sw.busy     = (state_q != S_IDLE);
  assign sw.done     = (state_q == S_FINISH);

`ifdef ACORE_PM_SWEEP_MAX_EN
  logic [PM_W-1:0]  max_data_q, max_data_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;

  always_comb begin
    max_data_d = max_data_q;
    max_idx_d  = max_idx_q;
    if (state_q == S_IDLE && sw.start && !sw.abort) begin
      max_data_d = '0;
      max_idx_d  = '0;
    end else if (res_wr_q && (res_data_q > max_data_q)) begin
      max_data_d = res_data_q;
      max_idx_d  = res_idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_data_q <= '0;
      max_idx_q  <= '0;
    end else begin
      max_data_q <= max_data_d;
      max_idx_q  <= max_idx_d;
    end
  end

  assign sw.max_data = max_data_q;
  assign sw.max_idx  = max_idx_q;
`endif
endmodule
